// File: rtl/kb_key_decoder_pkg.sv
// rtl/kb_key_decoder_pkg.sv - shared event layout, code encoding and FSM states for the key decoder
package kb_key_decoder_pkg;

  localparam int KB_EVT_CODE_LSB = 0;
  localparam int KB_EVT_CODE_MSB = 7;
  localparam int KB_EVT_PRESS    = 8;
  localparam int KB_EVT_MULTI    = 9;

  // One bit wider than a key code so NONE sorts above every real key in a min().
  localparam int KB_CODE_W = 9;
  localparam logic [KB_CODE_W-1:0] KB_CODE_NONE = 9'h100;

  typedef enum logic [1:0] {
    KB_IDLE     = 2'd0,
    KB_DEBOUNCE = 2'd1,
    KB_HELD     = 2'd2,
    KB_RELEASE  = 2'd3
  } kb_state_e;

  function automatic logic [KB_EVT_MULTI:0] kb_evt_fields(input logic [KB_CODE_W-1:0] code,
                                                          input logic press,
                                                          input logic multi);
    logic [KB_EVT_MULTI:0] f;
    f = '0;
    f[KB_EVT_CODE_MSB:KB_EVT_CODE_LSB] = code[KB_EVT_CODE_MSB-KB_EVT_CODE_LSB:0];
    f[KB_EVT_PRESS] = press;
    f[KB_EVT_MULTI] = multi;
    return f;
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// rtl/kb_event_fifo.sv - show-ahead event queue with drop-on-full sticky overflow
module kb_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/kb_key_decoder.sv
// rtl/kb_key_decoder.sv - scan-frame accumulator, debounce FSM and event queue for the key matrix
module kb_key_decoder
  import kb_key_decoder_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int STABLE_SCANS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_en,
  input  logic [COLS-1:0]   col_signal,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overflow
);

  localparam int CNT_W = $clog2(STABLE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SCANS);

  int                   zeros;
  int                   row_idx;
  int                   col_idx;
  int                   col_hits;
  logic                 sample_ok;
  logic                 sample_key;
  logic                 frame_end;
  logic [KB_CODE_W-1:0] sample_code;
  logic [KB_CODE_W-1:0] acc_code;
  logic                 acc_multi;
  logic [KB_CODE_W-1:0] res_code;
  logic                 res_multi;

  kb_state_e            state;
  logic [KB_CODE_W-1:0] cand;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 multi_acc;
  logic                 push;
  logic                 push_press;
  logic [KB_EVT_MULTI:0] evt_fields;
  logic [DATA_W-1:0]    push_data;

  // res_* is the frame result including the current sample; it is only consumed on frame_end.
  always_comb begin
    zeros    = 0;
    row_idx  = 0;
    col_idx  = 0;
    col_hits = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_en[r]) begin
        zeros++;
        row_idx = r;
      end
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_signal[c]) begin
        col_hits++;
        col_idx = c;
      end
    end
    sample_ok   = (zeros == 1);
    sample_key  = sample_ok && (col_hits != 0);
    sample_code = sample_key ? KB_CODE_W'(row_idx * COLS + col_idx) : KB_CODE_NONE;
    frame_end   = sample_ok && (row_idx == ROWS - 1);
    res_code    = (sample_code < acc_code) ? sample_code : acc_code;
    res_multi   = acc_multi | (sample_key && ((col_hits > 1) || (acc_code != KB_CODE_NONE)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_code  <= KB_CODE_NONE;
      acc_multi <= 1'b0;
    end else if (frame_end) begin
      acc_code  <= KB_CODE_NONE;
      acc_multi <= 1'b0;
    end else if (sample_ok) begin
      acc_code  <= res_code;
      acc_multi <= res_multi;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    push       = 1'b0;
    push_press = 1'b0;
    if (frame_end) begin
      case (state)
        KB_DEBOUNCE: if (res_code == cand && cnt_inc == CNT_MAX) begin
          push       = 1'b1;
          push_press = 1'b1;
        end
        KB_RELEASE: if (res_code == KB_CODE_NONE && cnt_inc == CNT_MAX) push = 1'b1;
        default: ;
      endcase
    end
    evt_fields = kb_evt_fields(cand, push_press, push_press && (multi_acc || res_multi));
    push_data  = DATA_W'(evt_fields);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KB_IDLE;
      cand      <= KB_CODE_NONE;
      cnt       <= '0;
      multi_acc <= 1'b0;
    end else if (frame_end) begin
      case (state)
        KB_IDLE: if (res_code != KB_CODE_NONE) begin
          state     <= KB_DEBOUNCE;
          cand      <= res_code;
          cnt       <= CNT_W'(1);
          multi_acc <= res_multi;
        end
        KB_DEBOUNCE: begin
          if (res_code == KB_CODE_NONE) begin
            state <= KB_IDLE;
            cnt   <= '0;
          end else if (res_code == cand) begin
            cnt       <= cnt_inc;
            multi_acc <= multi_acc | res_multi;
            if (cnt_inc == CNT_MAX) state <= KB_HELD;
          end else begin
            cand      <= res_code;
            cnt       <= CNT_W'(1);
            multi_acc <= res_multi;
          end
        end
        KB_HELD: if (res_code == KB_CODE_NONE) begin
          state <= KB_RELEASE;
          cnt   <= CNT_W'(1);
        end
        KB_RELEASE: begin
          if (res_code != KB_CODE_NONE) begin
            state <= KB_HELD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state <= KB_IDLE;
              cnt   <= '0;
            end
          end
        end
        default: state <= KB_IDLE;
      endcase
    end
  end

  kb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .clr_ovf   (clr_ovf),
    .head      (data),
    .valid     (valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_kb_key_decoder.sv
// tb/tb_kb_key_decoder.sv - randomized and directed bench against a frame-level debounce model
module tb_kb_key_decoder;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int S     = 3;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    row_en;
  logic [3:0]    col_signal;
  logic          rd_en;
  logic          clr_ovf;
  logic [DW-1:0] data;
  logic          valid;
  logic          overflow;

  kb_key_decoder #(
    .ROWS(ROWS), .COLS(COLS), .STABLE_SCANS(S), .FIFO_DEPTH(DEPTH), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_en(row_en), .col_signal(col_signal),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .data(data), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit [15:0]   keys;
  bit          m_held;
  int          m_key;
  int          m_run;
  bit          m_mor;
  bit          m_ovf;
  logic [31:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] evt(input int code, input bit press, input bit multi);
    logic [31:0] e;
    e = '0;
    e[7:0] = 8'(code);
    e[8]   = press;
    e[9]   = multi;
    return e;
  endfunction

  task automatic model_reset();
    m_held = 0; m_key = -1; m_run = 0; m_mor = 0; m_ovf = 0;
    q.delete();
  endtask

  // Debounce expressed as a run length of identical frame results.
  task automatic model_frame(output bit push, output logic [31:0] e);
    int res;
    bit m;
    push = 0;
    e    = '0;
    res  = -1;
    for (int k = 15; k >= 0; k--) if (keys[k]) res = k;
    m = ($countones(keys) > 1);
    if (!m_held) begin
      if (res < 0) m_run = 0;
      else if (m_run > 0 && res == m_key) begin m_run++; m_mor |= m; end
      else begin m_key = res; m_run = 1; m_mor = m; end
      if (m_run == S) begin push = 1; e = evt(m_key, 1, m_mor); m_held = 1; m_run = 0; end
    end else begin
      if (res < 0) m_run++; else m_run = 0;
      if (m_run == S) begin push = 1; e = evt(m_key, 0, 0); m_held = 0; m_run = 0; end
    end
  endtask

  task automatic model_edge(input logic [3:0] re, input bit rd, input bit cl);
    bit pop, push, drop;
    logic [31:0] e;
    pop  = rd && (q.size() > 0);
    push = 0;
    drop = 0;
    e    = '0;
    if ($countones(~re) == 1 && !re[3]) model_frame(push, e);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (cl) m_ovf = 0;
  endtask

  task automatic step(input logic [3:0] re, input bit rd, input bit cl);
    logic [3:0] cs;
    cs = 4'($urandom());
    if ($countones(~re) == 1)
      for (int r = 0; r < 4; r++)
        if (!re[r]) for (int c = 0; c < 4; c++) cs[c] = ~keys[r*4+c];
    row_en = re; col_signal = cs; rd_en = rd; clr_ovf = cl;
    @(posedge clk);
    model_edge(re, rd, cl);
    @(negedge clk);
    check("cyc.valid", 32'(valid), 32'(q.size() > 0));
    check("cyc.data", data, (q.size() > 0) ? q[0] : 32'h0);
    check("cyc.ovf", 32'(overflow), 32'(m_ovf));
    rd_en = 0; clr_ovf = 0;
  endtask

  task automatic frame(input bit junk, input bit rd_last, input bit clr_last);
    logic [3:0] pats [4];
    pats = '{4'b1111, 4'b1100, 4'b0000, 4'b0110};
    for (int r = 0; r < 4; r++) begin
      if (junk && $urandom_range(0, 1) == 1) step(pats[$urandom_range(0, 3)], 0, 0);
      step(~(4'b0001 << r), (r == 3) && rd_last, (r == 3) && clr_last);
    end
  endtask

  task automatic hold(input bit [15:0] k, input int n, input bit junk);
    keys = k;
    for (int i = 0; i < n; i++) frame(junk, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(4'b1111, 1, 0);
  endtask

  initial begin
    rst_n = 0; row_en = 4'hF; col_signal = 4'hF; rd_en = 0; clr_ovf = 0; keys = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(valid), 0);
    check("rst.data", data, 0);
    check("rst.ovf", 32'(overflow), 0);
    rst_n = 1;
    @(negedge clk);

    hold(16'h0200, 2, 0);
    check("press.early", 32'(valid), 0);
    hold(16'h0200, 1, 0);
    check("press.data", data, 32'h109);
    hold(16'h0000, 3, 0);
    check("rel.head", data, 32'h109);
    step(4'b1111, 1, 0);
    check("rel.data", data, 32'h009);
    step(4'b1111, 1, 0);
    check("rel.empty", 32'(valid), 0);

    hold(16'h0200, 2, 1);
    hold(16'h0000, 1, 1);
    hold(16'h0200, 2, 1);
    check("bounce.early", 32'(valid), 0);
    hold(16'h0200, 1, 1);
    check("bounce.data", data, 32'h109);
    hold(16'h0000, 3, 1);
    drain();

    hold(16'h0420, 3, 0);
    check("multi.data", data, 32'h305);
    hold(16'h0000, 3, 0);
    drain();

    for (int i = 0; i < 3; i++) begin
      hold(16'h0200, 3, 0);
      hold(16'h0000, 3, 0);
    end
    check("ovf.set", 32'(overflow), 1);
    check("ovf.head", data, 32'h109);
    step(4'b1111, 0, 1);
    check("ovf.clr", 32'(overflow), 0);
    hold(16'h0200, 2, 0);
    frame(0, 1, 0);
    check("ovf.pushpop", 32'(overflow), 0);
    check("ovf.pp_head", data, 32'h009);
    hold(16'h0000, 2, 0);
    frame(0, 0, 1);
    check("ovf.clr_drop", 32'(overflow), 1);
    drain();
    step(4'b1111, 0, 1);
    check("ovf.drained", 32'(valid), 0);

    hold(16'h0200, 2, 0);
    step(4'b1110, 0, 0);
    step(4'b1101, 0, 0);
    rst_n = 0;
    #2;
    check("mid_rst.valid", 32'(valid), 0);
    check("mid_rst.ovf", 32'(overflow), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    hold(16'h0200, 2, 0);
    check("post_rst.none", 32'(valid), 0);
    hold(16'h0200, 1, 0);
    check("post_rst.press", data, 32'h109);
    hold(16'h0000, 3, 0);
    drain();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: keys = '0;
          1: keys = 16'(1) << $urandom_range(0, 15);
          default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) step(4'b1111, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kb_key_decoder.md
# kb_key_decoder

Debounces and decodes the raw matrix-keyboard scan into key press/release events for the IO bus. It sits directly downstream of the keyboard row scanner, sampling the scanner's row enables together with the keyboard's column lines. It qualifies a key only after it is stable across several full scan frames. Qualified events are queued in a small show-ahead FIFO that the CPU-side IO read path drains with a read strobe.

## Interface
- ROWS, 4, keyboard rows; must match the scanner row count.
- COLS, 4, keyboard columns; ROWS*COLS ≤ 256.
- STABLE_SCANS, 8, consecutive identical frames required to qualify a press or release (≥ 2).
- FIFO_DEPTH, 4, event queue depth (power of 2).
- DATA_W, 32, IO bus data width.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- row_en  in  ROWS  scanner row enables, active-low; exactly one low bit selects the row being scanned.
- col_signal  in  COLS  keyboard column lines, active-low (0 = key pressed in the selected row).
- rd_en  in  1  pop head event; ignored when valid=0.
- clr_ovf  in  1  clears overflow.
- data  out  DATA_W  head event: [7:0] key code, [8] 1=press/0=release, [9] multi-key at press, rest 0; 0 when empty.
- valid  out  1  FIFO non-empty.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Per-cycle sample is valid only when row_en has exactly one 0 bit (row r). All-ones or multiple zeros: the cycle is ignored entirely and no frame end is produced.
- Valid sample with any col_signal bit low: the lowest low column c gives candidate code r*COLS+c. The frame accumulator keeps the minimum code seen in the frame and sets a multi flag if a second pressed key is seen (another column or another row).
- A frame ends on a valid sample of row ROWS-1. The frame result is the minimum code, or NONE (no key pressed). The accumulator clears for the next frame.
- Debounce FSM, evaluated at each frame end (cnt counts frames):
  - IDLE: result k → DEBOUNCE, cand=k, cnt=1.
  - DEBOUNCE: result == cand → cnt+1; when cnt reaches STABLE_SCANS, push press event and go to HELD. Result is a different key → restart with cand=new key, cnt=1. NONE → IDLE.
  - HELD: NONE → RELEASE, cnt=1. Any key → stay in HELD; other keys are ignored while a key is held.
  - RELEASE: NONE → cnt+1; when cnt reaches STABLE_SCANS, push release event (code=cand, multi=0) and go to IDLE. Any key → HELD with no event.
- The multi bit in a press event is the OR of the frame multi flags seen during DEBOUNCE.
- FIFO behaviour:
  - Show-ahead: data always shows the head entry.
  - Push when full: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both take effect and overflow is not set.
  - clr_ovf and a new drop in the same cycle: overflow stays 1.

## Timing
- Reset values: data=0, valid=0, overflow=0, FSM=IDLE, cnt=0, accumulator cleared, FIFO empty.
- Press latency: valid/data update on the clock edge that ends the last-row cycle of the STABLE_SCANS-th matching frame, i.e. one edge after that sample.
- Pop: when rd_en=1 and valid=1 at an edge, the next entry (or empty) is visible after that edge.
- Reset asserted mid-debounce or mid-frame: all state clears immediately. After release of reset, the first frame starts fresh and no partial event is emitted.
- cnt width is $clog2(STABLE_SCANS+1). cnt saturates and never wraps.

## Structure
- Shared package/param header defines: event field positions (KB_EVT_CODE_LSB/MSB, KB_EVT_PRESS, KB_EVT_MULTI), KB_CODE_NONE, and FSM state encodings.
- One sub-module: kb_event_fifo (parametrised depth/width, show-ahead, full/empty, drop-on-full overflow). The frame accumulator and FSM live in kb_key_decoder.

## Test plan
All scenarios use ROWS=COLS=4, STABLE_SCANS=3, and a rotating one-cold row_en.
- Key (row 2, col 1) held for 3 frames → one event, data=0x10_9 (code 9, press=1), valid rises exactly one edge after the third row-3 sample; releasing for 3 frames → data=0x009.
- Bounce: key 9 present for 2 frames, absent 1, present 3 → exactly one press event, emitted at the end of the sixth frame.
- Keys 5 and 10 pressed together for 3 frames → press code 5 with multi=1 (data=0x305).
- Six press/release events queued with no rd_en → 4 entries held, overflow=1; pop one while pushing at full → no further overflow; clr_ovf → overflow=0.
- row_en=4'b1111 or 4'b1100 cycles inserted mid-frame → ignored; event timing is unchanged apart from the stalled cycles.
- rst_n pulsed low during DEBOUNCE cnt=2 → valid=0 and no event; a subsequent 3 stable frames produce the press.
